// File: rtl/kmeans_pkg.sv
// ============================================================================
// kmeans_pkg : shared types and constants for the post-clustering stages.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package kmeans_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DRAIN  = 3'd2,
        SCALE  = 3'd3,
        DIVIDE = 3'd4,
        DONE   = 3'd5
    } sev_state_t;

    localparam logic [1:0] SEV_HEALTHY = 2'd0;
    localparam logic [1:0] SEV_MILD    = 2'd1;
    localparam logic [1:0] SEV_MOD     = 2'd2;
    localparam logic [1:0] SEV_SEVERE  = 2'd3;

    localparam int PCT_W     = 7;
    localparam int CNT_W     = 17;
    localparam int PROD_W    = 24;
    localparam int ADDR_W    = 16;
    localparam int DIV_ITERS = 23;

    // Thresholds are inclusive lower bounds, checked from most to least severe.
    function automatic logic [1:0] sev_classify(input logic [PCT_W-1:0] pct,
                                                input int th_mild,
                                                input int th_mod,
                                                input int th_sev);
        int p;
        p = int'(pct);
        if (p >= th_sev)       return SEV_SEVERE;
        else if (p >= th_mod)  return SEV_MOD;
        else if (p >= th_mild) return SEV_MILD;
        else                   return SEV_HEALTHY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/severity_estimator_seq_divider.sv
// ============================================================================
// seq_divider : restoring divider by a constant, one quotient bit per cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import kmeans_pkg::*;
#(
    parameter int DIVISOR = 40000,
    parameter int ITERS   = DIV_ITERS,
    parameter int QUO_W   = PCT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [PROD_W-1:0] i_dividend,
    output logic              o_done,
    output logic [QUO_W-1:0]  o_quotient
);

    localparam int REM_W  = $clog2(DIVISOR) + 2;
    localparam int CNT_BW = $clog2(ITERS + 1);

    logic [REM_W-1:0]  r_rem, w_src_rem, w_nrem;
    logic [PROD_W-1:0] r_quo, w_src_quo, w_nquo;
    logic [REM_W:0]    w_trial;
    logic              w_ge;
    logic [CNT_BW-1:0] r_cnt;
    logic              r_busy;
    logic              r_done;

    // The start cycle already performs the first iteration on the fresh
    // dividend; r_quo shifts dividend bits out of its MSB and quotient bits in.
    always_comb begin
        w_src_rem = i_start ? '0 : r_rem;
        w_src_quo = i_start ? (i_dividend << (PROD_W - ITERS)) : r_quo;
        w_trial   = {w_src_rem, w_src_quo[PROD_W-1]};
        w_ge      = (w_trial >= (REM_W+1)'(DIVISOR));
        w_nrem    = w_ge ? REM_W'(w_trial - (REM_W+1)'(DIVISOR)) : REM_W'(w_trial);
        w_nquo    = {w_src_quo[PROD_W-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= w_nrem;
                r_quo  <= w_nquo;
                r_cnt  <= CNT_BW'(1);
                r_busy <= (ITERS > 1);
                r_done <= (ITERS == 1);
            end else if (r_busy) begin
                r_rem <= w_nrem;
                r_quo <= w_nquo;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_BW'(ITERS - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo[QUO_W-1:0];

endmodule

`default_nettype wire

// File: rtl/severity_estimator.sv
// ============================================================================
// severity_estimator : counts diseased-cluster pixels and grades the area.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module severity_estimator
    import kmeans_pkg::*;
#(
    parameter int NUM_PIXELS = 40000,
    parameter int RD_LAT     = 1,
    parameter int TH_MILD    = 5,
    parameter int TH_MOD     = 25,
    parameter int TH_SEV     = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_severity,
    input  logic              diseased_cluster,
    output logic [ADDR_W-1:0] Cluster_ID_PORTB_addr,
    input  logic              Cluster_ID_PORTB_din,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  diseased_count,
    output logic [PCT_W-1:0]  severity_pct,
    output logic [1:0]        severity_class
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    sev_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [RD_LAT-1:0] r_vpipe;
    logic [1:0]        r_drain;
    logic              r_cluster;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_count;
    logic [PCT_W-1:0]  r_pct;
    logic [1:0]        r_class;
    logic [PROD_W-1:0] w_prod;
    logic [PCT_W-1:0]  w_quo;
    logic              w_accept, w_issue, w_valid, w_div_start, w_div_done;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_div_start = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                w_accept = start_severity;
                if (start_severity) w_next = SCAN;
            end
            SCAN: begin
                w_issue = 1'b1;
                if (r_addr == LAST_ADDR) w_next = DRAIN;
            end
            DRAIN:  if (r_drain == 2'(RD_LAT - 1)) w_next = SCALE;
            SCALE: begin
                w_div_start = 1'b1;
                w_next      = DIVIDE;
            end
            DIVIDE: if (w_div_done) w_next = DONE;
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_vpipe marks which cycles carry read data for an issued address.
    assign w_valid = r_vpipe[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_vpipe   <= '0;
            r_drain   <= '0;
            r_cluster <= 1'b0;
            r_acc     <= '0;
        end else begin
            r_vpipe <= RD_LAT'({r_vpipe, w_issue});
            r_drain <= (r_state == DRAIN) ? r_drain + 1'b1 : 2'd0;
            if (w_issue && r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
            else                                r_addr <= '0;
            if (w_accept) begin
                r_cluster <= diseased_cluster;
                r_acc     <= '0;
            end else if (w_valid && Cluster_ID_PORTB_din == r_cluster) begin
                r_acc <= r_acc + 1'b1;
            end
        end
    end

    // count*100 as shift-and-add: 64c + 32c + 4c.
    assign w_prod = (PROD_W'(r_acc) << 6) + (PROD_W'(r_acc) << 5) + (PROD_W'(r_acc) << 2);

    seq_divider #(
        .DIVISOR (NUM_PIXELS),
        .ITERS   (DIV_ITERS),
        .QUO_W   (PCT_W)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_dividend (w_prod),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    // Results are registered on the edge entering DONE so they are already
    // valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_pct   <= '0;
            r_class <= SEV_HEALTHY;
        end else if (r_state == DIVIDE && w_div_done) begin
            r_count <= r_acc;
            r_pct   <= w_quo;
            r_class <= sev_classify(w_quo, TH_MILD, TH_MOD, TH_SEV);
        end
    end

    assign Cluster_ID_PORTB_addr = r_addr;
    assign diseased_count        = r_count;
    assign severity_pct          = r_pct;
    assign severity_class        = r_class;

endmodule

`default_nettype wire

// File: tb/tb_severity_estimator.sv
// ============================================================================
// tb_severity_estimator : three parameterisations, scoreboard-checked.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_severity_estimator;

    localparam int NI   = 3;
    localparam int MEMD = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s [NI];
    logic        clus    [NI];
    logic [15:0] addr    [NI];
    logic        din     [NI];
    logic        busy    [NI];
    logic        done    [NI];
    logic [16:0] dcnt    [NI];
    logic [6:0]  pct     [NI];
    logic [1:0]  cls     [NI];
    logic        mem     [NI][MEMD];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int rst_cyc = -100;
    int rst_end = -100;
    int s_cyc [NI], done_cyc [NI], end_cyc [NI];
    int pend_cnt [NI], pend_pct [NI], pend_cls [NI];
    int hold_cnt [NI], hold_pct [NI], hold_cls [NI];

    typedef struct {
        int inst;
        int cnt;
        int pct;
        int cls;
        int cyc;
    } exp_t;
    exp_t sbq [$];

    function automatic int npix(input int j);
        return (j == 1) ? 40 : 16;
    endfunction

    function automatic int rlat(input int j);
        return (j == 2) ? 2 : 1;
    endfunction

    function automatic int ref_class(input int p);
        if (p >= 50) return 3;
        if (p >= 25) return 2;
        if (p >= 5)  return 1;
        return 0;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int P_N = (g == 1) ? 40 : 16;
            localparam int P_R = (g == 2) ? 2 : 1;
            logic [2:0] rd_pipe = '0;
            always @(posedge clk) rd_pipe <= {rd_pipe[1:0], mem[g][addr[g][5:0]]};
            assign din[g] = rd_pipe[P_R-1];

            severity_estimator #(
                .NUM_PIXELS (P_N),
                .RD_LAT     (P_R),
                .TH_MILD    (5),
                .TH_MOD     (25),
                .TH_SEV     (50)
            ) u_dut (
                .clk                   (clk),
                .reset                 (reset),
                .start_severity        (start_s[g]),
                .diseased_cluster      (clus[g]),
                .Cluster_ID_PORTB_addr (addr[g]),
                .Cluster_ID_PORTB_din  (din[g]),
                .busy                  (busy[g]),
                .done                  (done[g]),
                .diseased_count        (dcnt[g]),
                .severity_pct          (pct[g]),
                .severity_class        (cls[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input int j, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s inst %0d cycle %0d: got %0d expected %0d", nm, j, cyc, act, expv);
        end
    endtask

    // Called at a negedge; the start is sampled at the following posedge.
    task automatic issue_start(input int j, input bit c);
        int   n;
        exp_t e;
        start_s[j] = 1'b1;
        clus[j]    = c;
        if (cyc > end_cyc[j] && cyc > rst_end) begin
            n = 0;
            for (int i = 0; i < npix(j); i++) if (mem[j][i] == c) n++;
            e.inst = j;
            e.cnt  = n;
            e.pct  = (n * 100) / npix(j);
            e.cls  = ref_class(e.pct);
            e.cyc  = cyc + npix(j) + rlat(j) + 25;
            s_cyc[j]    = cyc;
            done_cyc[j] = e.cyc;
            end_cyc[j]  = e.cyc;
            pend_cnt[j] = e.cnt;
            pend_pct[j] = e.pct;
            pend_cls[j] = e.cls;
            sbq.push_back(e);
        end
        @(negedge clk);
        start_s[j] = 1'b0;
    endtask

    task automatic apply_reset(input int ncyc);
        reset   = 1'b1;
        rst_cyc = cyc;
        rst_end = cyc + ncyc - 1;
        for (int j = 0; j < NI; j++) begin
            if (end_cyc[j] > cyc)  end_cyc[j]  = cyc;
            if (done_cyc[j] > cyc) done_cyc[j] = -1;
        end
        sbq.delete();
        repeat (ncyc) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int j);
        while (cyc <= end_cyc[j]) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_ones(input int j, input int k);
        int placed;
        int pos;
        for (int i = 0; i < MEMD; i++) mem[j][i] = 1'b0;
        placed = 0;
        while (placed < k) begin
            pos = int'($urandom_range(0, npix(j) - 1));
            if (mem[j][pos] == 1'b0) begin
                mem[j][pos] = 1'b1;
                placed++;
            end
        end
    endtask

    // Monitor: per-cycle expectations from the timing model, plus the
    // scoreboard pop whenever a DUT raises done.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cyc == rst_cyc + 1) begin
                    for (int j = 0; j < NI; j++) begin
                        hold_cnt[j] = 0;
                        hold_pct[j] = 0;
                        hold_cls[j] = 0;
                    end
                end
                for (int j = 0; j < NI; j++) begin
                    int   ea;
                    exp_t e;
                    if (cyc == done_cyc[j]) begin
                        hold_cnt[j] = pend_cnt[j];
                        hold_pct[j] = pend_pct[j];
                        hold_cls[j] = pend_cls[j];
                    end
                    ea = (cyc > s_cyc[j] && cyc <= s_cyc[j] + npix(j) && cyc <= end_cyc[j])
                         ? cyc - s_cyc[j] - 1 : 0;
                    chk("busy", j, int'(busy[j]), int'(cyc > s_cyc[j] && cyc <= end_cyc[j]));
                    chk("addr", j, int'(addr[j]), ea);
                    chk("done", j, int'(done[j]), int'(cyc == done_cyc[j]));
                    chk("count_hold", j, int'(dcnt[j]), hold_cnt[j]);
                    chk("pct_hold", j, int'(pct[j]), hold_pct[j]);
                    chk("class_hold", j, int'(cls[j]), hold_cls[j]);
                    if (done[j]) begin
                        if (sbq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_empty inst %0d cycle %0d: got done expected none", j, cyc);
                        end else begin
                            e = sbq.pop_front();
                            chk("sb_inst", j, j, e.inst);
                            chk("sb_cycle", j, cyc, e.cyc);
                            chk("sb_count", j, int'(dcnt[j]), e.cnt);
                            chk("sb_pct", j, int'(pct[j]), e.pct);
                            chk("sb_class", j, int'(cls[j]), e.cls);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got no completion expected finish", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int j = 0; j < NI; j++) begin
            start_s[j]  = 1'b0;
            clus[j]     = 1'b0;
            s_cyc[j]    = -1000;
            done_cyc[j] = -1;
            end_cyc[j]  = -1;
            hold_cnt[j] = 0;
            hold_pct[j] = 0;
            hold_cls[j] = 0;
            for (int i = 0; i < MEMD; i++) mem[j][i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Alternating pattern: 8 of 16, 50 %, severe, done 42 cycles after start.
        for (int i = 0; i < 16; i++) mem[0][i] = logic'(i % 2);
        issue_start(0, 1'b1);
        wait_idle(0);

        // All zeros against cluster 1, then cluster 0 on the same memory.
        set_ones(0, 0);
        issue_start(0, 1'b1);
        wait_idle(0);
        issue_start(0, 1'b0);
        wait_idle(0);

        // 40 pixels: truncation to 7 %, the 25 % boundary, and 2 %.
        set_ones(1, 3);
        issue_start(1, 1'b1);
        wait_idle(1);
        set_ones(1, 10);
        issue_start(1, 1'b1);
        wait_idle(1);
        set_ones(1, 1);
        issue_start(1, 1'b1);
        wait_idle(1);

        // Two-cycle read latency, matches only at the first and last address.
        set_ones(2, 0);
        mem[2][0]  = 1'b1;
        mem[2][15] = 1'b1;
        issue_start(2, 1'b1);
        wait_idle(2);

        // Starts during SCAN and during DONE must be ignored.
        set_ones(0, int'($urandom_range(0, 16)));
        issue_start(0, 1'b1);
        repeat (4) @(negedge clk);
        issue_start(0, 1'b0);
        while (cyc < done_cyc[0]) @(negedge clk);
        issue_start(0, 1'b0);
        wait_idle(0);

        // Reset while address 7 is on the bus, then a clean rerun.
        set_ones(0, int'($urandom_range(0, 16)));
        issue_start(0, 1'b1);
        while (cyc < s_cyc[0] + 8) @(negedge clk);
        apply_reset(2);
        @(negedge clk);
        issue_start(0, 1'b1);
        wait_idle(0);

        // Randomised densities across all three parameterisations.
        repeat (9) begin
            int j;
            int dens;
            j    = int'($urandom_range(0, NI - 1));
            dens = int'($urandom_range(0, 100));
            for (int i = 0; i < MEMD; i++) mem[j][i] = logic'(int'($urandom_range(0, 99)) < dens);
            issue_start(j, bit'($urandom_range(0, 1)));
            wait_idle(j);
        end

        // Every cluster matching on the 40-pixel instance: 100 %.
        set_ones(1, 40);
        issue_start(1, 1'b1);
        wait_idle(1);

        chk("queue_empty", 0, sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
